// File: rtl/sca_pkg.sv
// Shared configuration for the carry-select adder with BEC upper blocks.
// Default geometry plus a helper used to reject an illegal WIDTH/BLOCK split.
package sca_pkg;

  localparam int SCA_WIDTH = 16;
  localparam int SCA_BLOCK = 4;
  localparam int SCA_NBLK  = SCA_WIDTH / SCA_BLOCK;

  // True when the word splits into whole blocks of at least two bits.
  function automatic bit sca_cfg_ok(input int width, input int block);
    return (block >= 2) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/bec_conv.sv
// Binary-to-excess-1 converter: x1 = x + 1 modulo 2^N, all-ones wraps to zero.
// Replaces the carry-in=1 ripple adder of a classic carry-select block.
module bec_conv #(
  parameter int N = 5
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] x1
);

  // Bit i toggles exactly when every lower bit is one.
  always_comb begin
    logic lower_ones;
    lower_ones = 1'b1;
    x1         = '0;
    for (int i = 0; i < N; i++) begin
      x1[i]      = x[i] ^ lower_ones;
      lower_ones = lower_ones & x[i];
    end
  end

endmodule

// File: rtl/select_carry_adder.sv
// Registered carry-select adder, {cout,sum} = A + B + cin, BEC-based upper blocks.
// Define SCA_INPUT_REG_EN to register A/B/cin first (2-cycle latency instead of 1).
module select_carry_adder
  import sca_pkg::*;
#(
  parameter int WIDTH = SCA_WIDTH,
  parameter int BLOCK = SCA_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             cout,
  output logic [WIDTH-1:0] sum
);

  localparam int NBLK = WIDTH / BLOCK;

  if (!sca_cfg_ok(WIDTH, BLOCK)) begin : g_bad_cfg
    $error("select_carry_adder: WIDTH must be a multiple of BLOCK and BLOCK >= 2");
  end

  // Bit-level ripple adder for one block; returns {carry, sum}.
  function automatic logic [BLOCK:0] rca(input logic [BLOCK-1:0] a,
                                         input logic [BLOCK-1:0] b,
                                         input logic             ci);
    logic [BLOCK:0] r;
    logic           c;
    c = ci;
    r = '0;
    for (int i = 0; i < BLOCK; i++) begin
      r[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    r[BLOCK] = c;
    return r;
  endfunction

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             cin_p0;

  // ---- stage 0: operand capture ----
`ifdef SCA_INPUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0   <= '0;
      b_p0   <= '0;
      cin_p0 <= 1'b0;
    end else begin
      a_p0   <= A;
      b_p0   <= B;
      cin_p0 <= cin;
    end
  end
`else
  assign a_p0   = A;
  assign b_p0   = B;
  assign cin_p0 = cin;
`endif

  // ---- stage 0 -> 1: carry-select adder ----
  logic [WIDTH-1:0] sum_c;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic c;

    if (k == 0) begin : g_rca
      logic [BLOCK:0] r;
      assign r                = rca(a_p0[BLOCK-1:0], b_p0[BLOCK-1:0], cin_p0);
      assign sum_c[BLOCK-1:0] = r[BLOCK-1:0];
      assign c                = r[BLOCK];
    end else begin : g_sel
      logic [BLOCK:0] r0;
      logic [BLOCK:0] r1;
      logic [BLOCK:0] rs;

      assign r0 = rca(a_p0[k*BLOCK +: BLOCK], b_p0[k*BLOCK +: BLOCK], 1'b0);

      bec_conv #(
        .N (BLOCK + 1)
      ) u_bec (
        .x  (r0),
        .x1 (r1)
      );

      assign rs                     = g_blk[k-1].c ? r1 : r0;
      assign sum_c[k*BLOCK +: BLOCK] = rs[BLOCK-1:0];
      assign c                      = rs[BLOCK];
    end
  end

  // ---- stage 1: result register ----
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
    end else begin
      sum_p1  <= sum_c;
      cout_p1 <= g_blk[NBLK-1].c;
    end
  end

  assign sum  = sum_p1;
  assign cout = cout_p1;

endmodule

// File: tb/tb_select_carry_adder.sv
// Scoreboard bench for select_carry_adder: directed vectors plus a random stream with a reset pulse.
// Honours SCA_INPUT_REG_EN (two-cycle latency) when defined.
module tb_select_carry_adder;

`ifdef SCA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a   = '0;
  logic [15:0] b   = '0;
  logic        cin = 1'b0;
  logic        cout;
  logic [15:0] sum;

  always #5 clk = ~clk;

  select_carry_adder dut (
    .clk  (clk),
    .rst  (rst),
    .A    (a),
    .B    (b),
    .cin  (cin),
    .cout (cout),
    .sum  (sum)
  );

  typedef struct {
    logic [16:0] val;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [16:0] prev_e = '0;

  // Drive one cycle of stimulus and queue the output expected after the next edge.
  task automatic drive(input logic r, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic [16:0] e, input int tag);
    exp_t        x;
    logic [16:0] e_now;
    @(negedge clk);
    rst   = r;
    a     = av;
    b     = bv;
    cin   = cv;
    e_now = r ? 17'd0 : e;
    if (LAT == 1) x.val = e_now;
    else          x.val = r ? 17'd0 : prev_e;
    prev_e = e_now;
    x.tag  = tag;
    sb.push_back(x);
  endtask

  // Monitor: one result per edge, compared against the head of the scoreboard.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if ({cout, sum} !== x.val) begin
          errors++;
          $display("FAIL vec%0d: got cout=%0b sum=%h, expected cout=%0b sum=%h",
                   x.tag, cout, sum, x.val[16], x.val[15:0]);
        end
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rr;

    // Reset held for two cycles with junk operands.
    drive(1'b1, 16'hABCD, 16'h1234, 1'b1, 17'h0_0000, 1);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h0_0000, 2);

    drive(1'b0, 16'h001F, 16'h000C, 1'b0, 17'h0_002B, 3);
    drive(1'b0, 16'hC61F, 16'h018C, 1'b1, 17'h0_C7AC, 4);
    drive(1'b0, 16'hFFFF, 16'h0000, 1'b1, 17'h1_0000, 5);
    drive(1'b0, 16'h9249, 16'h9249, 1'b1, 17'h1_2493, 6);
    drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF, 7);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 17'h0_0001, 8);
    drive(1'b0, 16'h0FFF, 16'h0001, 1'b0, 17'h0_1000, 9);
    drive(1'b0, 16'h8000, 16'h8000, 1'b0, 17'h1_0000, 10);
    drive(1'b0, 16'h00F0, 16'h0F10, 1'b0, 17'h0_1000, 11);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 17'h0_0000, 12);

    // Back-to-back random stream with a two-cycle reset pulse in the middle.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rr = (i == 20) || (i == 21);
      drive(rr, ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'd0, rc}, 100 + i);
    end

    // Flush the pipeline with a known operand so every queued result drains.
    drive(1'b0, 16'h1111, 16'h2222, 1'b0, 17'h0_3333, 200);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 17'h0_0000, 201);
    @(posedge clk);
    #3;

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still queued, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
